// File: rtl/braille_actuator_sequencer_if.sv
// Command / actuator bundle for the braille actuator sequencer.
//   master : command source (drives cmd_*, pulse_len; observes status)
//   slave  : the sequencer (accepts commands, drives act_*, dot_state,
//            busy, done_irq)
// NUM_CH and PW must match the sequencer instance using this bundle.
interface braille_actuator_sequencer_if #(
  parameter int NUM_CH = 8,
  parameter int PW     = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [NUM_CH-1:0] cmd_pattern;
  logic              cmd_mode;
  logic [PW-1:0]     pulse_len;
  logic [NUM_CH-1:0] act_set;
  logic [NUM_CH-1:0] act_clr;
  logic [NUM_CH-1:0] dot_state;
  logic              busy;
  logic              done_irq;

  modport master (
    output cmd_valid, cmd_pattern, cmd_mode, pulse_len,
    input  cmd_ready, act_set, act_clr, dot_state, busy, done_irq
  );

  modport slave (
    input  cmd_valid, cmd_pattern, cmd_mode, pulse_len,
    output cmd_ready, act_set, act_clr, dot_state, busy, done_irq
  );
endinterface

// File: rtl/braille_actuator_sequencer.sv
// Braille actuator sequencer: takes a target dot pattern and pulses the
// set/clear coils one group of GROUP channels at a time, so peak coil
// current stays bounded. Each pulse is followed by GAP_CYCLES of dead time.
// Ports:
//   wb_clk_i  clock
//   wb_rst_i  asynchronous active-high reset
//   bus       slave side of braille_actuator_sequencer_if
//             (cmd_valid/cmd_ready/cmd_pattern/cmd_mode/pulse_len in,
//              act_set/act_clr/dot_state/busy/done_irq out)
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// SCAN  | one cycle: does group g need a pulse?
// PULSE | drive coils of group g for plen cycles
// GAP   | dead time after a pulse, coils off
// DONE  | one-cycle done_irq, then back to IDLE
module braille_actuator_sequencer #(
  parameter int NUM_CH     = 8,
  parameter int GROUP      = 2,
  parameter int PW         = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic                          wb_clk_i,
  input logic                          wb_rst_i,
  braille_actuator_sequencer_if.slave  bus
);

  localparam int NG  = NUM_CH / GROUP;
  localparam int GIW = (NG > 1) ? $clog2(NG) : 1;
  localparam int GW  = $clog2(GAP_CYCLES + 1);
  localparam int CW  = (PW > GW) ? PW : GW;
  localparam logic [NUM_CH-1:0] GMASK0 = NUM_CH'((1 << GROUP) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [GIW-1:0]    g_q, g_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_CH-1:0] pat_q, pat_d;
  logic [NUM_CH-1:0] work_q, work_d;
  logic [PW-1:0]     plen_q, plen_d;
  logic [NUM_CH-1:0] dot_q, dot_d;

  logic [NUM_CH-1:0] gmask;
  logic [NUM_CH-1:0] gwork;
  logic [NUM_CH-1:0] act_set_c, act_clr_c;
  logic              g_last;

  assign gmask  = GMASK0 << (int'(g_q) * GROUP);
  assign gwork  = work_q & gmask;
  assign g_last = (g_q == GIW'(NG - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      work_q  <= '0;
      plen_q  <= PW'(1);
      dot_q   <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      work_q  <= work_d;
      plen_q  <= plen_d;
      dot_q   <= dot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    work_d    = work_q;
    plen_d    = plen_q;
    dot_d     = dot_q;
    act_set_c = '0;
    act_clr_c = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          pat_d   = bus.cmd_pattern;
          plen_d  = (bus.pulse_len == '0) ? PW'(1) : bus.pulse_len;
          work_d  = bus.cmd_mode ? '1 : (bus.cmd_pattern ^ dot_q);
          g_d     = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (gwork != '0) begin
          // plen >= 1, so the down-counter never wraps here
          cnt_d   = CW'(plen_q) - CW'(1);
          state_d = S_PULSE;
        end else if (g_last) begin
          state_d = S_DONE;
        end else begin
          g_d = g_q + GIW'(1);
        end
      end
      S_PULSE: begin
        act_set_c = gwork & pat_q;
        act_clr_c = gwork & ~pat_q;
        if (cnt_q == '0) begin
          // coils have finished moving: commit the worked bits of this group
          dot_d = (dot_q & ~gwork) | (pat_q & gwork);
          if (GAP_CYCLES > 0) begin
            cnt_d   = CW'(GAP_CYCLES - 1);
            state_d = S_GAP;
          end else if (g_last) begin
            state_d = S_DONE;
          end else begin
            g_d     = g_q + GIW'(1);
            state_d = S_SCAN;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == '0) begin
          if (g_last) begin
            state_d = S_DONE;
          end else begin
            g_d     = g_q + GIW'(1);
            state_d = S_SCAN;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Coil drive decodes straight from the async-reset state register, so
  // asserting reset drops the coils without waiting for a clock edge.
  assign bus.act_set   = act_set_c;
  assign bus.act_clr   = act_clr_c;
  assign bus.dot_state = dot_q;
  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done_irq  = (state_q == S_DONE);

endmodule

// File: tb/tb_braille_actuator_sequencer.sv
module tb_braille_actuator_sequencer;
  localparam int NUM_CH     = 8;
  localparam int GROUP      = 2;
  localparam int PW         = 8;
  localparam int GAP_CYCLES = 2;
  localparam int NG         = NUM_CH / GROUP;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;

  braille_actuator_sequencer_if #(.NUM_CH(NUM_CH), .PW(PW)) bus ();

  braille_actuator_sequencer #(
    .NUM_CH    (NUM_CH),
    .GROUP     (GROUP),
    .PW        (PW),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .bus     (bus)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct {
    logic [NUM_CH-1:0] set;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] dot;
    logic              busy;
    logic              irq;
    logic              rdy;
  } exp_t;

  exp_t              exp_q[$];
  int                vectors = 0;
  int                errors  = 0;
  logic [NUM_CH-1:0] dot_model;

  task automatic push_cyc(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] c,
                          input logic [NUM_CH-1:0] d, input logic b, input logic irq,
                          input logic r);
    exp_t e;
    e.set = s; e.clr = c; e.dot = d; e.busy = b; e.irq = irq; e.rdy = r;
    exp_q.push_back(e);
  endtask

  // Reference timeline: every group gets one scan cycle; groups with work
  // get plen drive cycles then GAP_CYCLES dead cycles; one done cycle ends it.
  task automatic build_trace(input logic [NUM_CH-1:0] pat, input logic mode,
                             input logic [PW-1:0] plen_in);
    logic [NUM_CH-1:0] work, m, dot, gm;
    int plen;
    work = mode ? '1 : (pat ^ dot_model);
    plen = (plen_in == 0) ? 1 : int'(plen_in);
    dot  = dot_model;
    exp_q.delete();
    for (int g = 0; g < NG; g++) begin
      push_cyc('0, '0, dot, 1'b1, 1'b0, 1'b0);
      gm = NUM_CH'((1 << GROUP) - 1) << (g * GROUP);
      m  = work & gm;
      if (m != 0) begin
        for (int k = 0; k < plen; k++) push_cyc(pat & m, ~pat & m, dot, 1'b1, 1'b0, 1'b0);
        dot = (dot & ~m) | (pat & m);
        for (int k = 0; k < GAP_CYCLES; k++) push_cyc('0, '0, dot, 1'b1, 1'b0, 1'b0);
      end
    end
    push_cyc('0, '0, dot, 1'b1, 1'b1, 1'b0);
    dot_model = dot;
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the
  // first idle cycle after done_irq.
  task automatic run_seq(input string tag, input logic [NUM_CH-1:0] pat, input logic mode,
                         input logic [PW-1:0] plen, input logic hold,
                         input logic [NUM_CH-1:0] npat, input logic nmode,
                         input logic [PW-1:0] nplen);
    exp_t e;
    bus.cmd_pattern = pat;
    bus.cmd_mode    = mode;
    bus.pulse_len   = plen;
    bus.cmd_valid   = 1'b1;
    vectors++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_accept: got %b want 1", tag, bus.cmd_ready);
    end
    build_trace(pat, mode, plen);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    if (hold) begin
      bus.cmd_pattern = npat;
      bus.cmd_mode    = nmode;
      bus.pulse_len   = nplen;
    end else begin
      bus.cmd_valid   = 1'b0;
      bus.cmd_pattern = NUM_CH'($urandom);
      bus.cmd_mode    = 1'($urandom);
      bus.pulse_len   = PW'($urandom);
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      e = exp_q[i];
      vectors++;
      if ({bus.act_set, bus.act_clr, bus.dot_state, bus.busy, bus.done_irq, bus.cmd_ready} !==
          {e.set, e.clr, e.dot, e.busy, e.irq, e.rdy}) begin
        errors++;
        $display("FAIL %s cycle %0d: got set=%h clr=%h dot=%h busy=%b irq=%b rdy=%b want set=%h clr=%h dot=%h busy=%b irq=%b rdy=%b",
                 tag, i + 1, bus.act_set, bus.act_clr, bus.dot_state, bus.busy, bus.done_irq,
                 bus.cmd_ready, e.set, e.clr, e.dot, e.busy, e.irq, e.rdy);
      end
      vectors++;
      if (((bus.act_set & bus.act_clr) != 0) || ($countones(bus.act_set | bus.act_clr) > GROUP)) begin
        errors++;
        $display("FAIL %s drive_limit cycle %0d: got set=%h clr=%h want disjoint and <=%0d bits",
                 tag, i + 1, bus.act_set, bus.act_clr, GROUP);
      end
      @(negedge wb_clk_i);
    end
    vectors++;
    if ({bus.busy, bus.cmd_ready, bus.done_irq, bus.dot_state} !== {1'b0, 1'b1, 1'b0, dot_model}) begin
      errors++;
      $display("FAIL %s idle_after_done: got busy=%b rdy=%b irq=%b dot=%h want 0 1 0 %h",
               tag, bus.busy, bus.cmd_ready, bus.done_irq, bus.dot_state, dot_model);
    end
  endtask

  task automatic test_reset;
    wb_rst_i        = 1'b1;
    bus.cmd_valid   = 1'b1;
    bus.cmd_pattern = 8'hFF;
    bus.cmd_mode    = 1'b1;
    bus.pulse_len   = 8'd3;
    repeat (3) @(negedge wb_clk_i);
    vectors++;
    if ({bus.act_set, bus.act_clr, bus.dot_state, bus.busy, bus.done_irq, bus.cmd_ready} !==
        {8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_hold: got set=%h clr=%h dot=%h busy=%b irq=%b rdy=%b want 00 00 00 0 0 1",
               bus.act_set, bus.act_clr, bus.dot_state, bus.busy, bus.done_irq, bus.cmd_ready);
    end
    bus.cmd_valid = 1'b0;
    wb_rst_i      = 1'b0;
    dot_model     = '0;
    @(negedge wb_clk_i);
  endtask

  task automatic test_delta_set;
    run_seq("delta_set", 8'h03, 1'b0, 8'd4, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_delta_mixed;
    run_seq("delta_mixed", 8'h0C, 1'b0, 8'd4, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_refresh;
    run_seq("refresh_prep", 8'hFF, 1'b0, 8'd3, 1'b0, '0, 1'b0, '0);
    run_seq("refresh", 8'hFF, 1'b1, 8'd4, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_noop;
    run_seq("noop", dot_model, 1'b0, 8'd5, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_zero_len;
    run_seq("zero_len_delta", 8'h5A, 1'b0, 8'd0, 1'b0, '0, 1'b0, '0);
    run_seq("zero_len_refresh", 8'hC3, 1'b1, 8'd0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back;
    run_seq("busy_first", 8'h33, 1'b0, 8'd2, 1'b1, 8'hA6, 1'b1, 8'd1);
    run_seq("busy_held", 8'hA6, 1'b1, 8'd1, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++) begin
      run_seq("random", NUM_CH'($urandom), 1'($urandom), PW'($urandom_range(0, 5)),
              1'b0, '0, 1'b0, '0);
    end
  endtask

  task automatic test_reset_mid_pulse;
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i        = 1'b0;
    dot_model       = '0;
    @(negedge wb_clk_i);
    bus.cmd_pattern = 8'h03;
    bus.cmd_mode    = 1'b0;
    bus.pulse_len   = 8'd4;
    bus.cmd_valid   = 1'b1;
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    bus.cmd_valid = 1'b0;
    @(negedge wb_clk_i);
    vectors++;
    if (bus.act_set !== 8'h03) begin
      errors++;
      $display("FAIL mid_pulse_drive: got set=%h want 03", bus.act_set);
    end
    #1 wb_rst_i = 1'b1;
    #1;
    vectors++;
    if ({bus.act_set, bus.act_clr, bus.dot_state, bus.cmd_ready, bus.busy} !==
        {8'h00, 8'h00, 8'h00, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL mid_pulse_reset: got set=%h clr=%h dot=%h rdy=%b busy=%b want 00 00 00 1 0",
               bus.act_set, bus.act_clr, bus.dot_state, bus.cmd_ready, bus.busy);
    end
    @(negedge wb_clk_i);
    wb_rst_i  = 1'b0;
    dot_model = '0;
    @(negedge wb_clk_i);
    run_seq("after_reset", 8'h81, 1'b0, 8'd1, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    test_reset();
    test_delta_set();
    test_delta_mixed();
    test_refresh();
    test_noop();
    test_zero_len();
    test_back_to_back();
    test_random();
    test_reset_mid_pulse();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
